// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
//   REGISTER_WIDTH / REG_INDEX_WIDTH / REGISTER_COUNT : register file geometry
//   REQ_ALU / REQ_LOAD / REQ_CSR                      : writeback requester IDs
package reg_wr_arbiter_pkg;

  localparam int unsigned REGISTER_WIDTH  = 32;
  localparam int unsigned REG_INDEX_WIDTH = 5;
  localparam int unsigned REGISTER_COUNT  = 32;
  localparam int unsigned NUM_REQ_DEFAULT = 3;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_CSR  = 2;

endpackage

// File: rtl/reg_wr_arbiter_rr_arbiter.sv
// Round-robin grant generator with its own pointer register.
//   clk, rst (async, active-low)
//   req_valid [NUM_REQ] : request lines
//   grant_c   [NUM_REQ] : combinational one-hot grant (zero while in reset)
// The pointer holds the last granted index; search starts one past it.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant_c
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_any;
  int unsigned      w_idx;

  // Scan from pointer+1 (with wrap) and take the first valid requester.
  always_comb begin
    grant_c   = '0;
    w_ptr_nxt = r_ptr;
    w_any     = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && req_valid[PTR_W'(w_idx)]) begin
        grant_c[PTR_W'(w_idx)] = 1'b1;
        w_ptr_nxt              = PTR_W'(w_idx);
        w_any                  = 1'b1;
      end
    end
    if (!rst) grant_c = '0;
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ptr <= PTR_W'(NUM_REQ - 1);
    else      r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the reg_file write port between NUM_REQ writeback sources and keeps
// a pending-write scoreboard for the issue stage.
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_index/req_data : per-requester write handshake
//   rsv_en/rsv_index                       : reserve a destination register
//   chk_index_n -> chk_busy_n              : source operand busy lookup
//   wr_en/wr_reg_index/wr_reg_data         : registered reg_file write port
//   busy_vec                               : scoreboard state
// Optional (macro REGFILE_BYPASS_EN): fwd_valid_n/fwd_data_n forward the
// in-flight write to a matching source operand before reg_file commits it.
module reg_wr_arbiter
  import reg_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int unsigned REGISTER_WIDTH  = reg_wr_arbiter_pkg::REGISTER_WIDTH,
  parameter int unsigned REG_INDEX_WIDTH = reg_wr_arbiter_pkg::REG_INDEX_WIDTH,
  parameter int unsigned REGISTER_COUNT  = reg_wr_arbiter_pkg::REGISTER_COUNT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*REG_INDEX_WIDTH-1:0]  req_index,
  input  logic [NUM_REQ*REGISTER_WIDTH-1:0]   req_data,
  input  logic                                rsv_en,
  input  logic [REG_INDEX_WIDTH-1:0]          rsv_index,
  input  logic [REG_INDEX_WIDTH-1:0]          chk_index_1,
  input  logic [REG_INDEX_WIDTH-1:0]          chk_index_2,
  output logic                                chk_busy_1,
  output logic                                chk_busy_2,
  output logic                                wr_en,
  output logic [REG_INDEX_WIDTH-1:0]          wr_reg_index,
  output logic [REGISTER_WIDTH-1:0]           wr_reg_data,
`ifdef REGFILE_BYPASS_EN
  output logic                                fwd_valid_1,
  output logic                                fwd_valid_2,
  output logic [REGISTER_WIDTH-1:0]           fwd_data_1,
  output logic [REGISTER_WIDTH-1:0]           fwd_data_2,
`endif
  output logic [REGISTER_COUNT-1:0]           busy_vec
);

  localparam int unsigned IW = REG_INDEX_WIDTH;
  localparam int unsigned DW = REGISTER_WIDTH;

  logic [NUM_REQ-1:0]        w_grant;
  logic                      w_xfer;
  logic [IW-1:0]             w_sel_index;
  logic [DW-1:0]             w_sel_data;
  logic [REGISTER_COUNT-1:0] w_busy_nxt;

  logic                      r_wr_en;
  logic [IW-1:0]             r_wr_index;
  logic [DW-1:0]             r_wr_data;
  logic [REGISTER_COUNT-1:0] r_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant_c   (w_grant)
  );

  assign req_ready = w_grant;

  // Mux the granted requester's payload.
  always_comb begin
    w_sel_index = '0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_index = req_index[i*IW +: IW];
        w_sel_data  = req_data[i*DW +: DW];
      end
    end
    w_xfer = |(req_valid & w_grant);
  end

  // Scoreboard next state: clear on transfer, then reserve so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) w_busy_nxt[w_sel_index] = 1'b0;
    if (rsv_en) w_busy_nxt[rsv_index]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Output register and scoreboard; x0 transfers are consumed without a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en    <= 1'b0;
      r_wr_index <= '0;
      r_wr_data  <= '0;
      r_busy     <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_sel_index != '0);
      if (w_xfer) begin
        r_wr_index <= w_sel_index;
        r_wr_data  <= w_sel_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_reg_index = r_wr_index;
  assign wr_reg_data  = r_wr_data;
  assign busy_vec     = r_busy;

  assign chk_busy_1 = (chk_index_1 != '0) && r_busy[chk_index_1];
  assign chk_busy_2 = (chk_index_2 != '0) && r_busy[chk_index_2];

`ifdef REGFILE_BYPASS_EN
  assign fwd_valid_1 = r_wr_en && (r_wr_index == chk_index_1) && (chk_index_1 != '0);
  assign fwd_valid_2 = r_wr_en && (r_wr_index == chk_index_2) && (chk_index_2 != '0);
  assign fwd_data_1  = r_wr_data;
  assign fwd_data_2  = r_wr_data;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter (NUM_REQ=3, 32x32 register file).
module tb_reg_wr_arbiter;
  import reg_wr_arbiter_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned IW = 5;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*IW-1:0] req_index;
  logic [NR*DW-1:0] req_data;
  logic           rsv_en;
  logic [IW-1:0]  rsv_index;
  logic [IW-1:0]  chk_index_1;
  logic [IW-1:0]  chk_index_2;
  logic           chk_busy_1;
  logic           chk_busy_2;
  logic           wr_en;
  logic [IW-1:0]  wr_reg_index;
  logic [DW-1:0]  wr_reg_data;
  logic [31:0]    busy_vec;
`ifdef REGFILE_BYPASS_EN
  logic           fwd_valid_1;
  logic           fwd_valid_2;
  logic [DW-1:0]  fwd_data_1;
  logic [DW-1:0]  fwd_data_2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [NR-1:0] exp_rdy [4];
  logic [IW-1:0] exp_idx [4];
  logic [DW-1:0] exp_dat [4];
  logic [NR-1:0] seen_rdy;

  reg_wr_arbiter #(.NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_data     (req_data),
    .rsv_en       (rsv_en),
    .rsv_index    (rsv_index),
    .chk_index_1  (chk_index_1),
    .chk_index_2  (chk_index_2),
    .chk_busy_1   (chk_busy_1),
    .chk_busy_2   (chk_busy_2),
    .wr_en        (wr_en),
    .wr_reg_index (wr_reg_index),
    .wr_reg_data  (wr_reg_data),
`ifdef REGFILE_BYPASS_EN
    .fwd_valid_1  (fwd_valid_1),
    .fwd_valid_2  (fwd_valid_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2),
`endif
    .busy_vec     (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [IW-1:0] idx, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_index[i*IW +: IW]  = idx;
    req_data[i*DW +: DW]   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_index = '0; req_data = '0;
    rsv_en = 1'b0; rsv_index = '0; chk_index_1 = '0; chk_index_2 = '0;

    // Reset state, with requests pending during reset
    set_req(REQ_ALU, 1'b1, 5'd1, 32'h1);
    set_req(REQ_LOAD, 1'b1, 5'd2, 32'h2);
    set_req(REQ_CSR, 1'b1, 5'd3, 32'h3);
    #12;
    check_val("rst_wr_en", 64'(wr_en), 64'd0);
    check_val("rst_wr_idx", 64'(wr_reg_index), 64'd0);
    check_val("rst_wr_data", 64'(wr_reg_data), 64'd0);
    check_val("rst_busy", 64'(busy_vec), 64'd0);
    check_val("rst_ready", 64'(req_ready), 64'd0);

    // Round-robin with all three valid continuously
    @(negedge clk);
    rst = 1'b1;
    set_req(REQ_ALU, 1'b1, 5'd5, 32'hAAAA_0001);
    set_req(REQ_LOAD, 1'b1, 5'd6, 32'hBBBB_0002);
    set_req(REQ_CSR, 1'b1, 5'd7, 32'hCCCC_0003);
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_idx = '{5'd5, 5'd6, 5'd7, 5'd5};
    exp_dat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hAAAA_0001};
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(exp_rdy[k]));
      step();
      check_val($sformatf("rr_wr_en%0d", k), 64'(wr_en), 64'd1);
      check_val($sformatf("rr_idx%0d", k), 64'(wr_reg_index), 64'(exp_idx[k]));
      check_val($sformatf("rr_data%0d", k), 64'(wr_reg_data), 64'(exp_dat[k]));
      @(negedge clk);
    end
    req_valid = '0;
    step();
    check_val("rr_idle_wr_en", 64'(wr_en), 64'd0);

    // x0 write: consumed but no reg_file write (pointer now 0 -> req 1 first)
    @(negedge clk);
    set_req(REQ_LOAD, 1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check_val("x0_ready", 64'(req_ready), 64'b010);
    step();
    check_val("x0_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    req_valid = '0;

    // Scoreboard reserve and check
    rsv_en = 1'b1; rsv_index = 5'd10; chk_index_1 = 5'd10; chk_index_2 = 5'd10;
    step();
    check_val("sb_rsv_busy", 64'(busy_vec), 64'h400);
    check_val("sb_chk1", 64'(chk_busy_1), 64'd1);
    check_val("sb_chk2", 64'(chk_busy_2), 64'd1);
    @(negedge clk);
    rsv_index = 5'd0;
    step();
    check_val("sb_rsv_x0", 64'(busy_vec), 64'h400);
    // ALU write to x10 clears on the wr_en edge (pointer 1 -> req 0)
    @(negedge clk);
    rsv_en = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd10, 32'h0000_1234);
    #1;
    check_val("sb_wr_ready", 64'(req_ready), 64'b001);
    step();
    check_val("sb_wr_en", 64'(wr_en), 64'd1);
    check_val("sb_wr_idx", 64'(wr_reg_index), 64'd10);
    check_val("sb_wr_data", 64'(wr_reg_data), 64'h1234);
    check_val("sb_clear", 64'(busy_vec), 64'd0);
    check_val("sb_clear_chk1", 64'(chk_busy_1), 64'd0);
    // Reserve and clear of x10 in the same cycle: reserve wins
    @(negedge clk);
    req_valid = '0;
    rsv_en = 1'b1; rsv_index = 5'd10;
    step();
    @(negedge clk);
    set_req(REQ_ALU, 1'b1, 5'd10, 32'h0000_5678);
    step();
    check_val("sb_same_wr_en", 64'(wr_en), 64'd1);
    check_val("sb_same_data", 64'(wr_reg_data), 64'h5678);
    check_val("sb_rsv_wins", 64'(busy_vec), 64'h400);
    // Double reserve, then a single write clears (no counting)
    @(negedge clk);
    req_valid = '0;
    step();
    @(negedge clk);
    rsv_en = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd10, 32'h0000_9ABC);
    step();
    check_val("sb_nocount_clear", 64'(busy_vec), 64'd0);
    check_val("sb_nocount_chk2", 64'(chk_busy_2), 64'd0);

    // Write x3 from CSR while operand 2 checks x3 (pointer 0 -> req 2 first)
    @(negedge clk);
    req_valid = '0;
    chk_index_1 = 5'd0; chk_index_2 = 5'd3;
    set_req(REQ_CSR, 1'b1, 5'd3, 32'h55AA_00FF);
    #1;
    check_val("byp_ready", 64'(req_ready), 64'b100);
    step();
    check_val("byp_wr_en", 64'(wr_en), 64'd1);
    check_val("byp_wr_data", 64'(wr_reg_data), 64'h55AA_00FF);
`ifdef REGFILE_BYPASS_EN
    check_val("byp_fwd_valid_2", 64'(fwd_valid_2), 64'd1);
    check_val("byp_fwd_data_2", 64'(fwd_data_2), 64'h55AA_00FF);
    check_val("byp_fwd_valid_1", 64'(fwd_valid_1), 64'd0);
`endif
    @(negedge clk);
    req_valid = '0;
    step();
`ifdef REGFILE_BYPASS_EN
    check_val("byp_fwd_drop", 64'(fwd_valid_2), 64'd0);
`endif

    // Contention: req 2 holds its payload while 0 and 1 win (pointer 2)
    @(negedge clk);
    set_req(REQ_ALU, 1'b1, 5'd11, 32'h1111_0000);
    set_req(REQ_LOAD, 1'b1, 5'd12, 32'h2222_0000);
    set_req(REQ_CSR, 1'b1, 5'd13, 32'h3333_0000);
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b000};
    exp_idx = '{5'd11, 5'd12, 5'd13, 5'd0};
    exp_dat = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h0};
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("hold_ready%0d", k), 64'(req_ready), 64'(exp_rdy[k]));
      seen_rdy = req_ready;
      step();
      check_val($sformatf("hold_idx%0d", k), 64'(wr_reg_index), 64'(exp_idx[k]));
      check_val($sformatf("hold_data%0d", k), 64'(wr_reg_data), 64'(exp_dat[k]));
      @(negedge clk);
      req_valid = req_valid & ~seen_rdy;
    end
    check_val("hold_all_served", 64'(req_valid), 64'd0);

    // Reset mid-operation
    set_req(REQ_ALU, 1'b1, 5'd21, 32'h2100_0000);
    set_req(REQ_LOAD, 1'b1, 5'd22, 32'h2200_0000);
    set_req(REQ_CSR, 1'b1, 5'd23, 32'h2300_0000);
    rsv_en = 1'b1; rsv_index = 5'd20;
    step();
    check_val("mid_pre_wr_en", 64'(wr_en), 64'd1);
    check_val("mid_pre_busy", 64'(busy_vec), 64'h0010_0000);
    rsv_en = 1'b0;
    rst = 1'b0;
    #1;
    check_val("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check_val("mid_rst_busy", 64'(busy_vec), 64'd0);
    check_val("mid_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    req_valid[REQ_LOAD] = 1'b0;
    #1;
    check_val("post_rst_ready", 64'(req_ready), 64'b001);
    step();
    check_val("post_rst_idx", 64'(wr_reg_index), 64'd21);
    @(negedge clk);
    req_valid = '0;
    step();
    check_val("post_rst_idle", 64'(wr_en), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares the single write port of reg_file between NUM_REQ writeback sources: ALU writeback, load unit and CSR/debug.
- Keeps a 32-entry pending-write scoreboard. The issue/decode stage reserves destination registers and checks its source operands against it.
- Sits between the multi-cycle control/writeback logic and reg_file. Outputs are registered and drive reg_file wr_en/wr_reg_index/wr_reg_data directly.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- REGISTER_WIDTH, 32, data width
- REG_INDEX_WIDTH, 5, register index width
- REGISTER_COUNT, 32, number of architectural registers

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero)
- req_index  in  NUM_REQ*REG_INDEX_WIDTH  packed destination indices; requester i uses slice i
- req_data  in  NUM_REQ*REGISTER_WIDTH  packed write data
- rsv_en  in  1  reserve a destination register this cycle
- rsv_index  in  REG_INDEX_WIDTH  register to reserve
- chk_index_1  in  REG_INDEX_WIDTH  source operand 1 to check
- chk_index_2  in  REG_INDEX_WIDTH  source operand 2 to check
- chk_busy_1  out  1  operand 1 has a pending write
- chk_busy_2  out  1  operand 2 has a pending write
- wr_en  out  1  to reg_file write enable
- wr_reg_index  out  REG_INDEX_WIDTH  to reg_file
- wr_reg_data  out  REGISTER_WIDTH  to reg_file
- busy_vec  out  REGISTER_COUNT  scoreboard state

Behaviour:
- Reset (rst low, async):
  - wr_en=0, wr_reg_index=0, wr_reg_data=0, busy_vec=0.
  - RR pointer=NUM_REQ-1, so requester 0 has highest priority first.
  - req_ready is all zero while rst is low.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid/index/data stable until it is granted.
  - req_ready never depends on the requester's own ready.
- Arbitration:
  - Round-robin, at most one grant per cycle.
  - Search begins at pointer+1 mod NUM_REQ.
  - The pointer updates to the granted index at the posedge of the transfer and holds when there is no grant.
- Latency:
  - Granted request appears on wr_en/wr_reg_index/wr_reg_data at the next posedge (1 cycle).
  - reg_file commits it at the following negedge.
  - wr_en is high for exactly one cycle per transfer. Back-to-back grants give continuous wr_en.
- x0 handling:
  - A request with index 0 is granted and consumed normally, but wr_en stays 0 for it.
  - rsv_en with rsv_index=0 is ignored; busy_vec[0] is always 0.
- Scoreboard:
  - rsv_en sets busy_vec[rsv_index] at posedge.
  - A transfer clears busy_vec[req_index] at the same posedge that loads wr_*.
  - When a reserve and a clear hit the same index in the same cycle, the reserve wins and the bit stays 1.
  - Reserving an already-busy register leaves it 1; there is no counting.
- Checks:
  - chk_busy_n = busy_vec[chk_index_n], combinational from registered state.
  - Index 0 always gives 0.
- Reset asserted mid-operation clears the scoreboard and pointer immediately and drops any in-flight wr_en. Pending requesters must re-present after reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Adds outputs fwd_valid_1, fwd_valid_2 (1 bit each) and fwd_data_1, fwd_data_2 (REGISTER_WIDTH each).
  - fwd_valid_n = wr_en && (wr_reg_index == chk_index_n) && chk_index_n != 0; fwd_data_n = wr_reg_data.
  - A consumer can take the value in the same cycle, before the reg_file negedge commit.
- Undefined: those ports are absent; consumers read reg_file only after the commit cycle.

Decomposition:
- Shared package/header: REGISTER_WIDTH, REG_INDEX_WIDTH, REGISTER_COUNT and the requester ID constants REQ_ALU=0, REQ_LOAD=1, REQ_CSR=2.
- One sub-module: rr_arbiter, a parameterised NUM_REQ round-robin grant generator with its pointer register.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset: drive rst low mid-traffic -> wr_en=0 and busy_vec=0 immediately; after release req 0 wins over req 2 when both are valid.
- RR fairness: all 3 valid continuously (idx 5,6,7; data A,B,C) -> wr_reg_index sequence 5,6,7,5 with wr_en high each cycle, 1-cycle latency.
- x0 write: req 1 valid, index 0, data 0xDEADBEEF -> req_ready[1]=1, wr_en stays 0, reg_file x0 unchanged.
- Scoreboard: rsv x10 -> chk_busy_1=1 for chk_index_1=10; ALU writes x10=0x1234 -> busy clears on the same posedge that wr_en rises; the same-cycle rsv_en of x10 keeps it busy.
- Hold under contention: req 2 valid while req 0,1 win -> req 2 data and index unchanged until granted, within NUM_REQ cycles.
- REGFILE_BYPASS_EN: write x3=0x55AA00FF while chk_index_2=3 -> fwd_valid_2=1, fwd_data_2=0x55AA00FF in the wr_en cycle; without the macro those ports are absent and the test is skipped.
